// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a checksummed program image over uart_rx,
// writes it into instruction memory and holds the core in reset until it verifies.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    S_SYNC, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } ld_state_t;

  logic          rx_s1, rx_s2, rx_q;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick;
  logic          byte_valid, framing_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  always_comb begin
    tick    = (rx_state == RX_START) ? (clk_cnt == HALF_M1)
                                     : (clk_cnt == FULL_M1);
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_q && !rx_s2) rx_next = RX_START;
      RX_START: if (tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      clk_cnt     <= (rx_state == RX_IDLE || tick) ? '0 : clk_cnt + 1'b1;
      if (rx_state == RX_DATA && tick) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (rx_state == RX_STOP && tick) begin
        byte_valid  <= rx_s2;
        framing_err <= !rx_s2;
      end
    end
  end

  ld_state_t     state, next;
  logic [ADDR_W:0] idx, n_words, len_n;
  logic [7:0]    csum;
  logic [23:0]   word;
  logic [1:0]    bcnt;
  logic [TW-1:0] tmo;
  logic          active, timeout, last_byte;

  always_comb begin
    active    = state inside {S_LEN, S_DATA, S_CSUM};
    timeout   = active && !byte_valid && tmo == TMO_M1;
    len_n     = (shreg == 8'd0) ? MAX_N : (ADDR_W+1)'(shreg);
    last_byte = bcnt == 2'd3 && idx + 1'b1 == n_words;
    next      = state;
    unique case (state)
      S_SYNC, S_ERR: if (byte_valid && shreg == 8'hA5) next = S_LEN;
      S_LEN:   if (byte_valid) next = S_DATA;
      S_DATA:  if (byte_valid && last_byte) next = S_CSUM;
      S_CSUM:  if (byte_valid) next = (shreg == csum) ? S_DONE : S_ERR;
      S_DONE:  next = S_DONE;
      default: next = S_ERR;
    endcase
    if (active && (framing_err || timeout)) next = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_SYNC;
    else     state <= next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      n_words <= '0;
      csum    <= '0;
      word    <= '0;
      bcnt    <= '0;
      tmo     <= '0;
      im_we   <= 1'b0;
      im_addr <= '0;
      im_din  <= '0;
      cpu_rst <= 1'b1;
    end else begin
      im_we   <= 1'b0;
      cpu_rst <= state != S_DONE;
      // byte_valid lands one cycle after the stop midpoint, so count it
      if (byte_valid)  tmo <= TW'(1);
      else if (active) tmo <= tmo + 1'b1;
      else             tmo <= '0;
      if (byte_valid) begin
        case (state)
          S_SYNC, S_ERR: begin
            idx  <= '0;
            csum <= '0;
            bcnt <= '0;
          end
          S_LEN: n_words <= len_n;
          S_DATA: begin
            csum <= csum + shreg;
            bcnt <= bcnt + 1'b1;
            word <= {word[15:0], shreg};
            if (bcnt == 2'd3) begin
              im_we   <= 1'b1;
              im_addr <= idx[ADDR_W-1:0];
              im_din  <= {word, shreg};
              idx     <= idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign done = state == S_DONE;
  assign err  = state == S_ERR;

endmodule
